// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared FSM state type and parameter defaults for the arbiter
package dm_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 256;
   localparam int ADDR_W_DEF = 8;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: two requester ports plus the data_memory side of the arbiter
interface dm_arbiter_if
   import dm_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic              p0_req, p0_we, p0_gnt, p0_done, p0_err;
   logic [31:0]       p0_adr;
   logic [DATA_W-1:0] p0_wdata, p0_rdata;
   logic              p1_req, p1_we, p1_gnt, p1_done, p1_err;
   logic [31:0]       p1_adr;
   logic [DATA_W-1:0] p1_wdata, p1_rdata;
   logic [31:0]       mem_read_adr, mem_write_adr;
   logic [DATA_W-1:0] mem_write_data, mem_read_data;
   logic              mem_memread, mem_memwrite;
   modport slave (
      input  p0_req, p0_we, p0_adr, p0_wdata, p1_req, p1_we, p1_adr, p1_wdata, mem_read_data,
      output p0_gnt, p0_done, p0_err, p0_rdata, p1_gnt, p1_done, p1_err, p1_rdata,
             mem_read_adr, mem_write_adr, mem_write_data, mem_memread, mem_memwrite
   );
   modport master (
      output p0_req, p0_we, p0_adr, p0_wdata, p1_req, p1_we, p1_adr, p1_wdata, mem_read_data,
      input  p0_gnt, p0_done, p0_err, p0_rdata, p1_gnt, p1_done, p1_err, p1_rdata,
             mem_read_adr, mem_write_adr, mem_write_data, mem_memread, mem_memwrite
   );
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; a lone requester wins, a tie goes to the port not granted last
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       win
);
   // tie-break on last_grant, otherwise port 1 wins only when it is the one asking
   always_comb win = &req ? !last_grant : req[1];
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of one data_memory between two requesters, one access per 3 cycles
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input logic        clk,
   input logic        reset,
   dm_arbiter_if.slave bus
);
   state_t            state, nxt;
   logic              we_q, id_q, last_grant, win, any_req, in_range;
   logic [31:0]       adr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   assign any_req  = bus.p0_req | bus.p1_req;
   assign in_range = adr_q < 32'(DEPTH) && (adr_q >> ADDR_W) == 32'd0;

   rr_arb2 u_rr (
      .req        ({bus.p1_req, bus.p0_req}),
      .last_grant (last_grant),
      .win        (win)
   );

   // state register; reset forces IDLE at once so the strobes drop asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   // requests are only looked at in IDLE; ACCESS and RESP always last one cycle each
   always_comb nxt = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;

   // latch the winner's request in IDLE and capture the read result at the edge ending ACCESS
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q       <= 1'b0;
         adr_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (state == IDLE && any_req) begin
            we_q       <= win ? bus.p1_we : bus.p0_we;
            adr_q      <= win ? bus.p1_adr : bus.p0_adr;
            wdata_q    <= win ? bus.p1_wdata : bus.p0_wdata;
            id_q       <= win;
            last_grant <= win;
         end
         if (state == ACCESS) rdata_q <= (in_range && !we_q) ? bus.mem_read_data : '0;
      end
   end

   // per-state outputs: grant in ACCESS, done/err/rdata in RESP, only for the latched winner
   always_comb begin
      bus.p0_gnt         = state == ACCESS && !id_q;
      bus.p1_gnt         = state == ACCESS && id_q;
      bus.p0_done        = state == RESP && !id_q;
      bus.p1_done        = state == RESP && id_q;
      bus.p0_err         = bus.p0_done && !in_range;
      bus.p1_err         = bus.p1_done && !in_range;
      bus.p0_rdata       = bus.p0_done ? rdata_q : '0;
      bus.p1_rdata       = bus.p1_done ? rdata_q : '0;
      bus.mem_read_adr   = adr_q;
      bus.mem_write_adr  = adr_q;
      bus.mem_write_data = wdata_q;
      bus.mem_memread    = state == ACCESS && in_range && !we_q;
      bus.mem_memwrite   = state == ACCESS && in_range && we_q;
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vector table plus hand-written reset/arbitration sequences
module tb_dm_arbiter;
   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] adr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mem [256];
   int          total = 0;
   int          bad = 0;

   dm_arbiter_if #(.DATA_W(32)) bus();
   dm_arbiter #(.DATA_W(32), .DEPTH(256), .ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // behavioural data_memory: combinational read, write on rising edge
   always @(posedge clk) if (bus.mem_memwrite) mem[bus.mem_write_adr[7:0]] <= bus.mem_write_data;
   assign bus.mem_read_data = mem[bus.mem_read_adr[7:0]];

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.p0_req = 0; bus.p0_we = 0; bus.p0_adr = 0; bus.p0_wdata = 0;
      bus.p1_req = 0; bus.p1_we = 0; bus.p1_adr = 0; bus.p1_wdata = 0;
   endtask

   task automatic check_quiet(input string name);
      chk({name, "_gnt"}, {30'd0, bus.p1_gnt, bus.p0_gnt}, 0);
      chk({name, "_done"}, {30'd0, bus.p1_done, bus.p0_done}, 0);
      chk({name, "_err"}, {30'd0, bus.p1_err, bus.p0_err}, 0);
      chk({name, "_strobe"}, {30'd0, bus.mem_memwrite, bus.mem_memread}, 0);
      chk({name, "_rdata"}, bus.p0_rdata | bus.p1_rdata, 0);
   endtask

   // called at #1 after an edge with the DUT in IDLE; returns likewise
   task automatic txn(input vec_t v);
      if (v.port) begin
         bus.p1_req = 1; bus.p1_we = v.we; bus.p1_adr = v.adr; bus.p1_wdata = v.wdata;
      end else begin
         bus.p0_req = 1; bus.p0_we = v.we; bus.p0_adr = v.adr; bus.p0_wdata = v.wdata;
      end
      @(posedge clk); #1;
      chk("gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, v.port ? 2 : 1);
      chk("done_early", {30'd0, bus.p1_done, bus.p0_done}, 0);
      chk("strobe", {30'd0, bus.mem_memwrite, bus.mem_memread}, v.err ? 0 : (v.we ? 2 : 1));
      if (!v.err) chk("mem_adr", v.we ? bus.mem_write_adr : bus.mem_read_adr, v.adr);
      bus.p0_req = 0; bus.p1_req = 0;
      @(posedge clk); #1;
      chk("done", {30'd0, bus.p1_done, bus.p0_done}, v.port ? 2 : 1);
      chk("gnt_resp", {30'd0, bus.p1_gnt, bus.p0_gnt}, 0);
      chk("err", {31'd0, v.port ? bus.p1_err : bus.p0_err}, {31'd0, v.err});
      chk("rdata", v.port ? bus.p1_rdata : bus.p0_rdata, v.rdata);
      chk("strobe_resp", {30'd0, bus.mem_memwrite, bus.mem_memread}, 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 0;
      idle_inputs();
      @(posedge clk); #1;
      check_quiet("reset");
      chk("reset_adr", bus.mem_read_adr, 0);
      chk("reset_wdata", bus.mem_write_data, 0);
      @(posedge clk); #1;
      reset = 1;
   endtask

   initial begin
      vec_t tbl [10];
      int   seq [4];
      int   ng;
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      idle_inputs();
      tbl[0] = '{0, 0, 32'd5,          32'd0,      32'd5,      0};
      tbl[1] = '{1, 1, 32'd10,         32'hF5,     32'd0,      0};
      tbl[2] = '{1, 0, 32'd10,         32'd0,      32'hF5,     0};
      tbl[3] = '{0, 0, 32'd256,        32'd0,      32'd0,      1};
      tbl[4] = '{1, 0, 32'd300,        32'd0,      32'd0,      1};
      tbl[5] = '{0, 1, 32'd7,          32'h1234,   32'd0,      0};
      tbl[6] = '{0, 0, 32'd7,          32'd0,      32'h1234,   0};
      tbl[7] = '{1, 0, 32'hFFFF_FFFF,  32'd0,      32'd0,      1};
      tbl[8] = '{1, 1, 32'd255,        32'hABCD,   32'd0,      0};
      tbl[9] = '{0, 0, 32'd255,        32'd0,      32'hABCD,   0};
      #2;
      do_reset();
      for (int i = 0; i < 10; i++) txn(tbl[i]);
      chk("oor_write_absent", mem[0], 0);

      do_reset();
      bus.p0_req = 1; bus.p0_adr = 1;
      bus.p1_req = 1; bus.p1_adr = 2;
      ng = 0;
      for (int c = 0; c < 30 && ng < 4; c++) begin
         @(posedge clk); #1;
         chk("two_gnt", {31'd0, bus.p0_gnt & bus.p1_gnt}, 0);
         if (bus.p0_gnt) seq[ng++] = 0;
         else if (bus.p1_gnt) seq[ng++] = 1;
      end
      chk("rr_count", ng, 4);
      for (int i = 0; i < ng; i++) chk("rr_order", seq[i], i % 2);
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;

      bus.p0_req = 1; bus.p0_we = 1; bus.p0_adr = 3; bus.p0_wdata = 32'hAA;
      @(posedge clk); #1;
      chk("pre_reset_write", {31'd0, bus.mem_memwrite}, 1);
      reset = 0;
      #1;
      chk("async_strobe", {30'd0, bus.mem_memwrite, bus.mem_memread}, 0);
      chk("async_gnt", {31'd0, bus.p0_gnt}, 0);
      idle_inputs();
      @(posedge clk); #1;
      chk("reset_no_done", {30'd0, bus.p1_done, bus.p0_done}, 0);
      reset = 1;
      @(posedge clk); #1;
      chk("reset_no_done2", {30'd0, bus.p1_done, bus.p0_done}, 0);
      chk("word3_kept", mem[3], 3);

      for (int i = 0; i < 256; i++) txn('{bit'(i % 2), 1'b1, 32'(i), 32'(255 - i), 32'd0, 1'b0});
      for (int i = 0; i < 256; i++) txn('{bit'((i + 1) % 2), 1'b0, 32'(i), 32'd0, 32'(255 - i), 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
